// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial LSB-first subtractor, one result bit per clock.
//            Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   ar_q, ar_d;     // minuend in, result shifts in behind it
    logic [WIDTH-1:0]   b_q, b_d;
    logic               bin_q, bin_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
    logic               ovf_q, ovf_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
`endif

    logic               diff_bit;
    logic               borrow_out;

    assign diff_bit   = ar_q[0] ^ b_q[0] ^ bin_q;
    assign borrow_out = (~ar_q[0] & b_q[0]) | (~(ar_q[0] ^ b_q[0]) & bin_q);

    always_comb begin
        state_d  = state_q;
        ar_d     = ar_q;
        b_d      = b_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d    = ovf_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    ar_d    = a;
                    b_d     = b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                ar_d  = {diff_bit, ar_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                bin_d = borrow_out;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    diff_d   = {diff_bit, ar_q[WIDTH-1:1]};
                    borrow_d = borrow_out;
                    done_d   = 1'b1;
                    state_d  = IDLE;
`ifdef SERIAL_SUB_OVF_EN
                    // diff_bit is the MSB of the completed result
                    ovf_d    = (a_msb_q != b_msb_q) & (diff_bit != a_msb_q);
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ar_q     <= '0;
            b_q      <= '0;
            bin_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ar_q     <= ar_d;
            b_q      <= b_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= ovf_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
`endif
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Directed self-checking bench for serial_subtractor (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One isolated operation; operands are scrambled while RUN to prove they are ignored.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] exp_diff,
                         input logic exp_borrow, input logic exp_ovf, input string tag);
        int cyc;
        int busy_cnt;
        logic [7:0] held;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        busy_cnt = 0;
        while (!done && cyc < 20) begin
            if (busy) busy_cnt++;
            a = 8'($urandom);
            b = 8'($urandom);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(WIDTH));
        check({tag, "_busycycles"}, 64'(busy_cnt), 64'(WIDTH));
        check({tag, "_diff"}, 64'(diff), 64'(exp_diff));
        check({tag, "_borrow"}, 64'(borrow), 64'(exp_borrow));
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
`endif
        held = diff;
        @(posedge clk); #1;
        check({tag, "_donepulse"}, 64'(done), 64'(0));
        check({tag, "_hold"}, 64'(diff), 64'(held));
    endtask

    initial begin
        int cyc;
        int done_seen;
        logic [7:0] bb_a [3];
        logic [7:0] bb_b [3];
        logic [7:0] bb_d [3];

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   64'(busy),   64'(0));
        check("rst_done",   64'(done),   64'(0));
        check("rst_diff",   64'(diff),   64'(0));
        check("rst_borrow", 64'(borrow), 64'(0));
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf",    64'(ovf),    64'(0));
`endif
        rst = 1'b0;

        do_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "op_05_03");
        do_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "op_03_05");
        do_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, "op_ff_ff");
        do_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, "op_00_01");
        do_op(8'h00, 8'h5A, 8'hA6, 1'b1, 1'b0, "op_00_5a");
        do_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "op_80_01");
        do_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, "op_10_01");
        do_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "op_00_00");
        do_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "op_7f_ff");

        // Abort in the 4th RUN cycle; outputs must clear and no done may follow.
        @(negedge clk);
        a = 8'h33; b = 8'h11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy",   64'(busy),   64'(0));
        check("abort_done",   64'(done),   64'(0));
        check("abort_diff",   64'(diff),   64'(0));
        check("abort_borrow", 64'(borrow), 64'(0));
`ifdef SERIAL_SUB_OVF_EN
        check("abort_ovf",    64'(ovf),    64'(0));
`endif
        rst = 1'b0;
        done_seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'(0));
        do_op(8'h09, 8'h04, 8'h05, 1'b0, 1'b0, "after_abort");

        // Back-to-back with start held high.
        bb_a[0] = 8'h20; bb_b[0] = 8'h07; bb_d[0] = 8'h19;
        bb_a[1] = 8'h01; bb_b[1] = 8'h02; bb_d[1] = 8'hFF;
        bb_a[2] = 8'hC8; bb_b[2] = 8'h64; bb_d[2] = 8'h64;
        @(negedge clk);
        a = bb_a[0]; b = bb_b[0]; start = 1'b1;
        @(posedge clk); #1;
        a = 8'($urandom); b = 8'($urandom);
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            do begin
                @(posedge clk); #1;
                cyc++;
                if (!done) begin
                    a = 8'($urandom);
                    b = 8'($urandom);
                end
            end while (!done && cyc < 30);
            check($sformatf("b2b%0d_spacing", k), 64'(cyc), (k == 0) ? 64'(WIDTH) : 64'(WIDTH + 1));
            check($sformatf("b2b%0d_diff", k), 64'(diff), 64'(bb_d[k]));
            if (k < 2) begin
                a = bb_a[k+1];
                b = bb_b[k+1];
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk); #1;
        check("b2b_idle", 64'(busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
